mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: ACCESS cycles without mem_ready before abort; used only with MEM_ARB_TIMEOUT_EN.
REQ-002 clk  in  1  sole clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 f_req  in  1  fetch requester (IR load) access request; read-only.
REQ-005 f_addr  in  32  fetch address.
REQ-006 d_req  in  1  data requester (load/store) access request.
REQ-007 d_we  in  1  data access is a write when 1.
REQ-008 d_addr  in  32  data address.
REQ-009 d_wdata  in  32  data write value.
REQ-010 f_gnt, d_gnt  out  1 each  one-cycle pulse: request accepted, inputs captured.
REQ-011 f_done, d_done  out  1 each  one-cycle pulse: access complete.
REQ-012 rdata  out  32  read result; valid while done is high.
REQ-013 err  out  1  timeout abort flag; valid while done is high.
REQ-014 mem_addr  out  32  memory address.
REQ-015 mem_wdata  out  32  memory write data.
REQ-016 mem_read, mem_write  out  1 each  memory strobes.
REQ-017 mem_rdata  in  32  memory read data.
REQ-018 mem_ready  in  1  memory completes the current access at this edge.

Function
REQ-019 FSM states: IDLE, ACCESS, RESP.
REQ-020 IDLE, edge with any req high: capture owner, address, we, wdata; go to ACCESS.
REQ-021 Both reqs high in IDLE: data wins; fetch stays pending.
REQ-022 Fetch captured with we forced 0 and wdata 0.
REQ-023 First ACCESS cycle: owner gnt high for exactly one cycle.
REQ-024 ACCESS: mem_addr/mem_wdata drive the captured values; mem_read = !we, mem_write = we; both strobes never high together.
REQ-025 ACCESS, edge with mem_ready=1: rdata <= mem_rdata on reads, or 0 on writes; err <= 0; go to RESP.
REQ-026 RESP: owner done high for one cycle; strobes low; next state IDLE.
REQ-027 Minimum latency: req sampled at edge N; gnt and strobe in cycle N+1; with mem_ready, done in cycle N+2; next acceptance at edge N+3.
REQ-028 Requester holds req and inputs until gnt and drops req after gnt. Req still high in IDLE after done is a new request.
REQ-029 Req/input changes in ACCESS/RESP have no effect on the access in flight.
REQ-030 Outside RESP, rdata and err hold their last value; done is 0.
REQ-031 mem_addr and mem_wdata are 0 outside ACCESS.

Reset
REQ-032 rst sampled high: state IDLE, all outputs 0, capture registers 0, timeout counter 0.
REQ-033 Reset mid-ACCESS or RESP: strobes drop in the cycle after the edge; no done or gnt issued; the access is lost.
REQ-034 rst has priority over every other transition.

Configuration
REQ-035 With MEM_ARB_TIMEOUT_EN defined: counter clears on ACCESS entry and increments each ACCESS cycle without mem_ready.
REQ-036 With MEM_ARB_TIMEOUT_EN, on reaching TIMEOUT_CYCLES: go to RESP with err=1, rdata=0.
REQ-037 With MEM_ARB_TIMEOUT_EN, mem_ready on the same edge as expiry wins: normal completion, err=0.
REQ-038 Without MEM_ARB_TIMEOUT_EN: ACCESS waits indefinitely; err is constant 0; no counter logic is present.

Structure
REQ-039 Package mem_arb_pkg holds: state enum (IDLE/ACCESS/RESP), owner enum (OWN_FETCH/OWN_DATA), TIMEOUT_CYCLES default.
REQ-040 One sub-module, mem_arb_timer (clear/enable/expired), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-041 Fetch read: f_req=1, f_addr=0x100, mem_ready=1 immediately, mem_rdata=0xDEADBEEF -> f_gnt at N+1, mem_read at N+1, f_done at N+2, rdata=0xDEADBEEF, err=0.
REQ-042 Simultaneous reqs: f_addr=0x200, d_addr=0x400 -> data served first (mem_addr=0x400, d_gnt); after d_done, fetch served (mem_addr=0x200, f_gnt).
REQ-043 Store with 3 wait states: d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_write high 4 cycles, mem_read 0; d_done one cycle after mem_ready; rdata=0.
REQ-044 Timeout (macro on, TIMEOUT_CYCLES=16), mem_ready held 0 -> done with err=1, rdata=0 after 16 ACCESS cycles. Macro off: still in ACCESS after 100 cycles, err=0.
REQ-045 Reset mid-ACCESS: rst=1 on 2nd wait cycle -> strobes 0 next cycle, no done, state IDLE; new f_req afterwards completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog for mem_port_arbiter; only compiled when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear on access entry, otherwise count stalled cycles.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Fires on the edge that ends the TIMEOUT_CYCLES-th stalled cycle.
  assign expired = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for a fetch and a data requester (data has priority).
// Optional access timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        f_gnt,
  output logic        d_gnt,
  output logic        f_done,
  output logic        d_done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  logic        f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
  logic        f_done_q, f_done_d, d_done_q, d_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;

`ifdef MEM_ARB_TIMEOUT_EN
  logic tmr_clear_s, tmr_enable_s, tmr_expired_s;

  mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear_s),
    .enable  (tmr_enable_s),
    .expired (tmr_expired_s)
  );
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (TIMEOUT_CYCLES != 32'd0);
`endif

  // Next-state and output logic; the mem_* registers double as the capture registers.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    f_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    f_done_d    = 1'b0;
    d_done_d    = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
`ifdef MEM_ARB_TIMEOUT_EN
    tmr_clear_s  = 1'b0;
    tmr_enable_s = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d     = ACCESS;
          owner_d     = OWN_DATA;
          d_gnt_d     = 1'b1;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_read_d  = !d_we;
          mem_write_d = d_we;
`ifdef MEM_ARB_TIMEOUT_EN
          tmr_clear_s = 1'b1;
`endif
        end else if (f_req) begin
          state_d     = ACCESS;
          owner_d     = OWN_FETCH;
          f_gnt_d     = 1'b1;
          mem_addr_d  = f_addr;
          mem_wdata_d = 32'd0;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
          tmr_clear_s = 1'b1;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
`ifdef MEM_ARB_TIMEOUT_EN
        tmr_enable_s = !mem_ready;
`endif
        if (mem_ready) begin
          state_d     = RESP;
          rdata_d     = mem_write_q ? 32'd0 : mem_rdata;
          err_d       = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wdata_d = 32'd0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (owner_q == OWN_DATA) begin
            d_done_d = 1'b1;
          end else begin
            f_done_d = 1'b1;
          end
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (tmr_expired_s) begin
          state_d     = RESP;
          rdata_d     = 32'd0;
          err_d       = 1'b1;
          mem_addr_d  = 32'd0;
          mem_wdata_d = 32'd0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (owner_q == OWN_DATA) begin
            d_done_d = 1'b1;
          end else begin
            f_done_d = 1'b1;
          end
`endif
        end else begin
          state_d = ACCESS;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_addr_d  = 32'd0;
        mem_wdata_d = 32'd0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      f_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      f_gnt_q     <= f_gnt_d;
      d_gnt_q     <= d_gnt_d;
      f_done_q    <= f_done_d;
      d_done_q    <= d_done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign f_gnt     = f_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign f_done    = f_done_q;
  assign d_done    = d_done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model, directed cases, random traffic.
module tb_mem_port_arbiter;

  localparam int TMO = 16;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, f_req, d_req, d_we, mem_ready;
  logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic        f_gnt, d_gnt, f_done, d_done, err, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .f_gnt(f_gnt), .d_gnt(d_gnt), .f_done(f_done), .d_done(d_done),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // expected outputs for the current cycle
  logic        e_fg, e_dg, e_fd, e_dd, e_err, e_rd, e_wr;
  logic [31:0] e_rdata, e_addr, e_wdata;
  // the access in flight, as a transaction
  bit          m_inflight = 1'b0;
  bit          m_resp = 1'b0;
  bit          m_own_data, m_we;
  int          m_age;
  logic [31:0] m_addr, m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Apply one clock edge to the transaction model using the inputs seen at that edge.
  task automatic model_step();
    e_fg = 1'b0; e_dg = 1'b0; e_fd = 1'b0; e_dd = 1'b0;
    if (rst) begin
      m_inflight = 1'b0; m_resp = 1'b0;
      e_rdata = 32'd0; e_err = 1'b0; e_addr = 32'd0; e_wdata = 32'd0;
      e_rd = 1'b0; e_wr = 1'b0;
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (m_inflight) begin
      m_age++;
      if (mem_ready || (TMO_EN && m_age >= TMO)) begin
        e_err   = !mem_ready;
        e_rdata = (mem_ready && !m_we) ? mem_rdata : 32'd0;
        if (m_own_data) e_dd = 1'b1; else e_fd = 1'b1;
        m_inflight = 1'b0; m_resp = 1'b1;
        e_addr = 32'd0; e_wdata = 32'd0; e_rd = 1'b0; e_wr = 1'b0;
      end
    end else if (d_req || f_req) begin
      m_own_data = d_req;
      m_we       = d_req ? d_we : 1'b0;
      m_addr     = d_req ? d_addr : f_addr;
      m_wdata    = d_req ? d_wdata : 32'd0;
      m_inflight = 1'b1; m_age = 0;
      if (d_req) e_dg = 1'b1; else e_fg = 1'b1;
      e_addr = m_addr; e_wdata = m_wdata; e_rd = !m_we; e_wr = m_we;
    end
  endtask

  task automatic compare_all();
    chk("f_gnt", {31'd0, f_gnt}, {31'd0, e_fg});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, e_dg});
    chk("f_done", {31'd0, f_done}, {31'd0, e_fd});
    chk("d_done", {31'd0, d_done}, {31'd0, e_dd});
    chk("rdata", rdata, e_rdata);
    chk("err", {31'd0, err}, {31'd0, e_err});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_read", {31'd0, mem_read}, {31'd0, e_rd});
    chk("mem_write", {31'd0, mem_write}, {31'd0, e_wr});
    chk("strobe_excl", {31'd0, mem_read & mem_write}, 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int wr_cycles;
    int done_seen;
    bit f_pend, d_pend;
    int rdy_pct;

    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    cyc(); cyc();
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_gnt", {30'd0, f_gnt, d_gnt}, 32'd0);
    rst = 1'b0;
    cyc();

    // fetch read, zero wait states
    f_req = 1'b1; f_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    cyc();
    chk("fr_gnt", {31'd0, f_gnt}, 32'd1);
    chk("fr_read", {31'd0, mem_read}, 32'd1);
    chk("fr_addr", mem_addr, 32'h100);
    f_req = 1'b0;
    cyc();
    chk("fr_done", {31'd0, f_done}, 32'd1);
    chk("fr_rdata", rdata, 32'hDEADBEEF);
    chk("fr_err", {31'd0, err}, 32'd0);
    mem_ready = 1'b0; mem_rdata = 32'h0BAD_F00D;
    cyc();
    chk("fr_hold", rdata, 32'hDEADBEEF);

    // simultaneous requests: data first, fetch after
    f_req = 1'b1; f_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    cyc();
    chk("sim_dgnt", {31'd0, d_gnt}, 32'd1);
    chk("sim_fgnt0", {31'd0, f_gnt}, 32'd0);
    chk("sim_addr_d", mem_addr, 32'h400);
    d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    cyc();
    chk("sim_ddone", {31'd0, d_done}, 32'd1);
    mem_ready = 1'b0;
    cyc();
    cyc();
    chk("sim_fgnt", {31'd0, f_gnt}, 32'd1);
    chk("sim_addr_f", mem_addr, 32'h200);
    f_req = 1'b0; mem_ready = 1'b1;
    cyc();
    chk("sim_fdone", {31'd0, f_done}, 32'd1);
    mem_ready = 1'b0;
    cyc();

    // store with three wait states
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; mem_rdata = 32'hFFFF_FFFF;
    wr_cycles = 0;
    cyc();
    chk("st_wdata", mem_wdata, 32'h12345678);
    wr_cycles += int'(mem_write);
    d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("st_read0", {31'd0, mem_read}, 32'd0);
      wr_cycles += int'(mem_write);
    end
    mem_ready = 1'b1;
    cyc();
    chk("st_wr_cycles", wr_cycles, 32'd4);
    chk("st_done", {31'd0, d_done}, 32'd1);
    chk("st_rdata", rdata, 32'd0);
    mem_ready = 1'b0; d_we = 1'b0;
    cyc();

    // stalled access: timeout if enabled, otherwise wait indefinitely
    d_req = 1'b1; d_addr = 32'h80;
    cyc();
    d_req = 1'b0;
    done_seen = 0;
    if (TMO_EN) begin
      for (int i = 0; i < TMO - 1; i++) begin
        cyc();
        done_seen += int'(d_done);
      end
      chk("tmo_early", done_seen, 32'd0);
      cyc();
      chk("tmo_done", {31'd0, d_done}, 32'd1);
      chk("tmo_err", {31'd0, err}, 32'd1);
      chk("tmo_rdata", rdata, 32'd0);
    end else begin
      for (int i = 0; i < 100; i++) begin
        cyc();
        done_seen += int'(d_done);
      end
      chk("wait_nodone", done_seen, 32'd0);
      chk("wait_read", {31'd0, mem_read}, 32'd1);
      chk("wait_err", {31'd0, err}, 32'd0);
      mem_ready = 1'b1;
      cyc();
      chk("wait_done", {31'd0, d_done}, 32'd1);
      mem_ready = 1'b0;
    end
    cyc();

    // reset in the middle of an access
    f_req = 1'b1; f_addr = 32'h300;
    cyc();
    f_req = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("rm_read", {31'd0, mem_read}, 32'd0);
    chk("rm_addr", mem_addr, 32'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      done_seen += int'(f_done);
    end
    chk("rm_nodone", done_seen, 32'd0);
    f_req = 1'b1; f_addr = 32'h304; mem_ready = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    cyc();
    chk("rm_gnt", {31'd0, f_gnt}, 32'd1);
    f_req = 1'b0;
    cyc();
    chk("rm_done", {31'd0, f_done}, 32'd1);
    chk("rm_rdata", rdata, 32'hA5A5_5A5A);
    mem_ready = 1'b0;
    cyc();

    // random traffic against the model
    f_pend = 1'b0; d_pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rdy_pct = ((i / 400) % 2 == 1) ? 3 : 40;
      rst = ($urandom_range(0, 199) == 0);
      if (f_pend && e_fg) begin
        f_pend = 1'b0; f_req = 1'b0;
      end else if (!f_pend) begin
        f_addr = $urandom;
        if ($urandom_range(0, 3) == 0) begin
          f_pend = 1'b1; f_req = 1'b1;
        end
      end
      if (d_pend && e_dg) begin
        d_pend = 1'b0; d_req = 1'b0;
      end else if (!d_pend) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 3) == 0) begin
          d_pend = 1'b1; d_req = 1'b1;
        end
      end
      mem_ready = ($urandom_range(0, 99) < rdy_pct);
      mem_rdata = $urandom;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
